// File: rtl/noc_output_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the router output scheduler: the fixed port ordering
// (N, S, E, W, Local), the flit width and type, and a small helper that turns
// a one-hot network grant into a port index.
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int FLIT_WIDTH = 32;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

  // One-hot network grant to port index; a zero or malformed vector maps to 0.
  function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/noc_output_scheduler_if.sv
// -----------------------------------------------------------------------------
// noc_output_scheduler_if
// Bundles the VC-side pop interface, the downstream valid/ready link and the
// credit return path of the output scheduler.
//   vc_empty      per-VC empty flags            (to scheduler)
//   vc_data       per-VC head flits, packed     (to scheduler)
//   grant         one-hot pop strobe            (from scheduler)
//   out_packet    registered output flit        (from scheduler)
//   out_valid     output flit valid             (from scheduler)
//   out_ready     downstream accepts flit       (to scheduler)
//   credit_in     downstream freed one slot     (to scheduler)
//   credits_avail current credit count          (from scheduler)
//   credit_err    sticky credit overflow flag   (from scheduler)
// master = scheduler side, slave = environment (VCs + downstream router).
// -----------------------------------------------------------------------------
interface noc_output_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 4
);
  import noc_pkg::*;

  localparam int CW = $clog2(CREDITS + 1);

  logic [NUM_PORTS-1:0]            vc_empty;
  logic [NUM_PORTS*DATA_WIDTH-1:0] vc_data;
  logic [NUM_PORTS-1:0]            grant;
  logic [DATA_WIDTH-1:0]           out_packet;
  logic                            out_valid;
  logic                            out_ready;
  logic                            credit_in;
  logic [CW-1:0]                   credits_avail;
  logic                            credit_err;

  modport master (
    input  vc_empty, vc_data, out_ready, credit_in,
    output grant, out_packet, out_valid, credits_avail, credit_err
  );

  modport slave (
    output vc_empty, vc_data, out_ready, credit_in,
    input  grant, out_packet, out_valid, credits_avail, credit_err
  );

endinterface

// File: rtl/noc_output_scheduler_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational 4-input rotating-priority picker. The requester at index ptr
// has highest priority, then ptr+1, ptr+2, ptr+3 (mod 4).
//   req  [3:0]  request vector
//   ptr  [1:0]  highest-priority index
//   gnt  [3:0]  one-hot grant (zero when no request)
//   any         at least one request present
// -----------------------------------------------------------------------------
module rr_priority_picker (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       any
);

  logic [1:0] idx_s;

  // Walk the four priority slots starting at ptr; the first requester wins.
  always_comb begin
    gnt   = 4'b0000;
    idx_s = 2'd0;
    for (int off = 0; off < 4; off++) begin
      idx_s = ptr + 2'(off);
      if ((gnt == 4'b0000) && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
      end else begin
        gnt = gnt;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/noc_output_scheduler.sv
// -----------------------------------------------------------------------------
// noc_output_scheduler
// Shares one router output link among the N, S, E, W and Local virtual
// channels. At most one non-empty VC is popped per cycle via a one-hot grant;
// the popped flit is registered onto a valid/ready link. Every grant consumes a
// downstream credit, so the neighbour's input buffer cannot overflow. Network
// ports rotate round-robin; Local only wins when the network is idle, except
// that after STARVE_LIMIT lost eligible cycles it is force-granted.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         noc_output_scheduler_if.master (VC pop, output link, credits)
// -----------------------------------------------------------------------------
module noc_output_scheduler
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH   = FLIT_WIDTH,
  parameter int CREDITS      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  noc_output_scheduler_if.master bus
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [NUM_PORTS-1:0]  req_s;
  logic [NUM_PORTS-1:0]  grant_s;
  logic [3:0]            net_gnt_s;
  logic                  net_any_s;
  logic                  slot_free_s;
  logic                  eligible_s;
  logic                  local_grant_s;
  logic                  net_fire_s;
  logic                  any_grant_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  logic [1:0]            rr_ptr_r;
  logic [SW-1:0]         starve_r;
  logic [CW-1:0]         credits_r;
  logic                  credit_err_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_packet_r;

  assign req_s = ~bus.vc_empty;

  rr_priority_picker u_picker (
    .req (req_s[3:0]),
    .ptr (rr_ptr_r),
    .gnt (net_gnt_s),
    .any (net_any_s)
  );

  // Grant decision: slot/credit gating, Local vs. network choice, data mux.
  always_comb begin
    grant_s    = {NUM_PORTS{1'b0}};
    sel_data_s = {DATA_WIDTH{1'b0}};
    // The output register can take a new flit if empty or draining this cycle.
    slot_free_s = !out_valid_r || bus.out_ready;
    // rst_n is included so the combinational pop stays quiet during reset.
    eligible_s  = rst_n && slot_free_s && (credits_r != {CW{1'b0}});
    local_grant_s = eligible_s && req_s[PORT_L] &&
                    (!net_any_s || (starve_r == STARVE_MAX));
    net_fire_s  = eligible_s && net_any_s && !local_grant_s;
    if (local_grant_s) begin
      grant_s[PORT_L] = 1'b1;
    end else if (net_fire_s) begin
      grant_s[3:0] = net_gnt_s;
    end else begin
      grant_s = {NUM_PORTS{1'b0}};
    end
    any_grant_s = |grant_s;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_s[i]) begin
        sel_data_s = bus.vc_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Round-robin pointer: move just past the served network port; Local grants leave it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= 2'd0;
    end else if (net_fire_s) begin
      rr_ptr_r <= onehot4_to_idx(net_gnt_s) + 2'd1;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Starvation counter: counts eligible cycles Local loses, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_r <= {SW{1'b0}};
    end else if (!req_s[PORT_L] || local_grant_s) begin
      starve_r <= {SW{1'b0}};
    end else if (eligible_s && (starve_r != STARVE_MAX)) begin
      starve_r <= starve_r + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      starve_r <= starve_r;
    end
  end

  // Credit counter: a grant reserves a slot, credit_in returns one; overflow is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_r    <= CREDIT_MAX;
      credit_err_r <= 1'b0;
    end else begin
      case ({any_grant_s, bus.credit_in})
        2'b10: begin
          credits_r    <= credits_r - {{(CW-1){1'b0}}, 1'b1};
          credit_err_r <= credit_err_r;
        end
        2'b01: begin
          if (credits_r == CREDIT_MAX) begin
            credits_r    <= credits_r;
            credit_err_r <= 1'b1;
          end else begin
            credits_r    <= credits_r + {{(CW-1){1'b0}}, 1'b1};
            credit_err_r <= credit_err_r;
          end
        end
        default: begin
          credits_r    <= credits_r;
          credit_err_r <= credit_err_r;
        end
      endcase
    end
  end

  // Output register: load on grant, clear once accepted, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_packet_r <= {DATA_WIDTH{1'b0}};
    end else if (any_grant_s) begin
      out_valid_r  <= 1'b1;
      out_packet_r <= sel_data_s;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r  <= 1'b0;
      out_packet_r <= out_packet_r;
    end else begin
      out_valid_r  <= out_valid_r;
      out_packet_r <= out_packet_r;
    end
  end

  assign bus.grant         = grant_s;
  assign bus.out_packet    = out_packet_r;
  assign bus.out_valid     = out_valid_r;
  assign bus.credits_avail = credits_r;
  assign bus.credit_err    = credit_err_r;

endmodule

// File: tb/tb_noc_output_scheduler.sv
// -----------------------------------------------------------------------------
// tb_noc_output_scheduler
// Self-checking bench for noc_output_scheduler. Each scenario task drives the
// VCs, checks grants/credits/output inline, and pushes the flit it expects to
// see on the link; a link monitor pops and compares on every accepted flit.
// -----------------------------------------------------------------------------
module tb_noc_output_scheduler;

  logic clk;
  logic rst_n;

  int checks = 0;
  int fails  = 0;

  logic [31:0] data_arr [5];
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  noc_output_scheduler_if #(.DATA_WIDTH(32), .CREDITS(4)) bus ();

  noc_output_scheduler #(
    .DATA_WIDTH   (32),
    .CREDITS      (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Link monitor: every accepted flit must match the oldest expected flit.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL flit_unexpected: got %h, expected no flit", bus.out_packet);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.out_packet !== mon_exp) begin
            fails++;
            $display("FAIL flit_data: got %h, expected %h", bus.out_packet, mon_exp);
          end
        end
      end
    end
  end

  task automatic set_data;
    bus.vc_data = {data_arr[4], data_arr[3], data_arr[2], data_arr[1], data_arr[0]};
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL flits_missing: %0d expected flits never appeared, expected 0", exp_q.size());
    end
    exp_q.delete();
    rst_n = 1'b0;
    bus.vc_empty  = 5'b11111;
    bus.credit_in = 1'b0;
    bus.out_ready = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) data_arr[i] = 32'h1111_0000 + 32'(i);
    set_data();
    bus.vc_empty  = 5'b00000;
    bus.out_ready = 1'b1;
    bus.credit_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.grant !== 5'b00000) begin fails++; $display("FAIL reset_grant: got %b, expected 00000", bus.grant); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, expected 0", bus.out_valid); end
    checks++; if (bus.out_packet !== 32'h0) begin fails++; $display("FAIL reset_packet: got %h, expected 0", bus.out_packet); end
    checks++; if (bus.credits_avail !== 3'd4) begin fails++; $display("FAIL reset_credits: got %0d, expected 4", bus.credits_avail); end
    checks++; if (bus.credit_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, expected 0", bus.credit_err); end
    step();
    bus.vc_empty = 5'b11111;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    data_arr[0] = 32'hA5A5_0001;
    set_data();
    bus.vc_empty = 5'b11110;
    @(negedge clk);
    checks++; if (bus.grant !== 5'b00001) begin fails++; $display("FAIL single_grant: got %b, expected 00001", bus.grant); end
    exp_q.push_back(32'hA5A5_0001);
    step();
    bus.vc_empty = 5'b11111;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b, expected 1", bus.out_valid); end
    checks++; if (bus.out_packet !== 32'hA5A5_0001) begin fails++; $display("FAIL single_packet: got %h, expected a5a50001", bus.out_packet); end
    checks++; if (bus.credits_avail !== 3'd3) begin fails++; $display("FAIL single_credits: got %0d, expected 3", bus.credits_avail); end
    checks++; if (bus.grant !== 5'b00000) begin fails++; $display("FAIL single_idle_grant: got %b, expected 00000", bus.grant); end
    step();
    bus.credit_in = 1'b1;
    step();
    bus.credit_in = 1'b0;
    @(negedge clk);
    checks++; if (bus.credits_avail !== 3'd4) begin fails++; $display("FAIL single_credit_return: got %0d, expected 4", bus.credits_avail); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_drained: got %b, expected 0", bus.out_valid); end
  endtask

  task automatic test_round_robin;
    logic [4:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) data_arr[i] = 32'hB000_0000 + 32'(i);
    set_data();
    bus.vc_empty  = 5'b10000;
    bus.credit_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      @(negedge clk);
      exp_g = 5'b00001 << (c % 4);
      checks++; if (bus.grant !== exp_g) begin fails++; $display("FAIL rr_grant[%0d]: got %b, expected %b", c, bus.grant, exp_g); end
      checks++; if (bus.credits_avail !== 3'd4) begin fails++; $display("FAIL rr_credits_same_cycle[%0d]: got %0d, expected 4", c, bus.credits_avail); end
      exp_q.push_back(data_arr[c % 4]);
    end
    step();
    bus.vc_empty  = 5'b11111;
    bus.credit_in = 1'b0;
    @(negedge clk);
    checks++; if (bus.credit_err !== 1'b0) begin fails++; $display("FAIL rr_no_err: got %b, expected 0", bus.credit_err); end
  endtask

  task automatic test_starvation;
    logic [4:0] exp_g;
    do_reset();
    data_arr[0] = 32'hC000_0000;
    data_arr[4] = 32'hC000_0004;
    set_data();
    bus.vc_empty  = 5'b01110;
    bus.credit_in = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) step();
      @(negedge clk);
      exp_g = ((c % 9) == 8) ? 5'b10000 : 5'b00001;
      checks++; if (bus.grant !== exp_g) begin fails++; $display("FAIL starve_grant[%0d]: got %b, expected %b", c, bus.grant, exp_g); end
      exp_q.push_back(((c % 9) == 8) ? data_arr[4] : data_arr[0]);
    end
    step();
    bus.vc_empty  = 5'b11111;
    bus.credit_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_credit_exhaustion;
    logic [4:0] exp_g;
    logic [2:0] exp_c;
    do_reset();
    data_arr[1] = 32'hD000_0001;
    set_data();
    bus.vc_empty = 5'b11101;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      @(negedge clk);
      exp_c = (c < 4) ? 3'(4 - c) : 3'd0;
      exp_g = (c < 4) ? 5'b00010 : 5'b00000;
      checks++; if (bus.credits_avail !== exp_c) begin fails++; $display("FAIL exh_credits[%0d]: got %0d, expected %0d", c, bus.credits_avail, exp_c); end
      checks++; if (bus.grant !== exp_g) begin fails++; $display("FAIL exh_grant[%0d]: got %b, expected %b", c, bus.grant, exp_g); end
      if (c < 4) exp_q.push_back(data_arr[1]);
    end
    step();
    bus.credit_in = 1'b1;
    @(negedge clk);
    checks++; if (bus.grant !== 5'b00000) begin fails++; $display("FAIL exh_zero_block: got %b, expected 00000", bus.grant); end
    step();
    bus.credit_in = 1'b0;
    @(negedge clk);
    checks++; if (bus.credits_avail !== 3'd1) begin fails++; $display("FAIL exh_one_credit: got %0d, expected 1", bus.credits_avail); end
    checks++; if (bus.grant !== 5'b00010) begin fails++; $display("FAIL exh_extra_grant: got %b, expected 00010", bus.grant); end
    exp_q.push_back(data_arr[1]);
    step();
    @(negedge clk);
    checks++; if (bus.grant !== 5'b00000) begin fails++; $display("FAIL exh_blocked_again: got %b, expected 00000", bus.grant); end
    checks++; if (bus.credits_avail !== 3'd0) begin fails++; $display("FAIL exh_back_to_zero: got %0d, expected 0", bus.credits_avail); end
    step();
    bus.vc_empty  = 5'b11111;
    bus.credit_in = 1'b1;
    repeat (3) step();
    step();
    bus.credit_in = 1'b0;
    @(negedge clk);
    checks++; if (bus.credits_avail !== 3'd4) begin fails++; $display("FAIL exh_refill: got %0d, expected 4", bus.credits_avail); end
    checks++; if (bus.credit_err !== 1'b0) begin fails++; $display("FAIL exh_no_err: got %b, expected 0", bus.credit_err); end
  endtask

  task automatic test_back_pressure;
    do_reset();
    data_arr[2] = 32'hE000_0002;
    set_data();
    bus.vc_empty = 5'b11011;
    @(negedge clk);
    checks++; if (bus.grant !== 5'b00100) begin fails++; $display("FAIL bp_first_grant: got %b, expected 00100", bus.grant); end
    exp_q.push_back(32'hE000_0002);
    step();
    bus.out_ready = 1'b0;
    data_arr[2] = 32'hE000_0012;
    set_data();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.grant !== 5'b00000) begin fails++; $display("FAIL bp_stall_grant[%0d]: got %b, expected 00000", i, bus.grant); end
      checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_stall_valid[%0d]: got %b, expected 1", i, bus.out_valid); end
      checks++; if (bus.out_packet !== 32'hE000_0002) begin fails++; $display("FAIL bp_stall_packet[%0d]: got %h, expected e0000002", i, bus.out_packet); end
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.grant !== 5'b00100) begin fails++; $display("FAIL bp_release_grant: got %b, expected 00100", bus.grant); end
    exp_q.push_back(32'hE000_0012);
    step();
    bus.vc_empty = 5'b11111;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_no_bubble_valid: got %b, expected 1", bus.out_valid); end
    checks++; if (bus.out_packet !== 32'hE000_0012) begin fails++; $display("FAIL bp_no_bubble_packet: got %h, expected e0000012", bus.out_packet); end
    step();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b, expected 0", bus.out_valid); end
    checks++; if (bus.credits_avail !== 3'd2) begin fails++; $display("FAIL bp_credits: got %0d, expected 2", bus.credits_avail); end
    step();
    bus.credit_in = 1'b1;
    step();
    step();
    bus.credit_in = 1'b0;
  endtask

  task automatic test_boundary;
    do_reset();
    bus.credit_in = 1'b1;
    @(negedge clk);
    checks++; if (bus.credit_err !== 1'b0) begin fails++; $display("FAIL bnd_err_before: got %b, expected 0", bus.credit_err); end
    step();
    bus.credit_in = 1'b0;
    @(negedge clk);
    checks++; if (bus.credit_err !== 1'b1) begin fails++; $display("FAIL bnd_overflow_err: got %b, expected 1", bus.credit_err); end
    checks++; if (bus.credits_avail !== 3'd4) begin fails++; $display("FAIL bnd_overflow_count: got %0d, expected 4", bus.credits_avail); end
    step();
    @(negedge clk);
    checks++; if (bus.credit_err !== 1'b1) begin fails++; $display("FAIL bnd_err_sticky: got %b, expected 1", bus.credit_err); end
    // One grant to get off the full count, then grant and credit together.
    data_arr[0] = 32'hF000_0000;
    set_data();
    step();
    bus.vc_empty = 5'b11110;
    @(negedge clk);
    exp_q.push_back(data_arr[0]);
    step();
    bus.credit_in = 1'b1;
    @(negedge clk);
    checks++; if (bus.grant !== 5'b00001) begin fails++; $display("FAIL bnd_sim_grant: got %b, expected 00001", bus.grant); end
    checks++; if (bus.credits_avail !== 3'd3) begin fails++; $display("FAIL bnd_sim_before: got %0d, expected 3", bus.credits_avail); end
    exp_q.push_back(data_arr[0]);
    step();
    bus.credit_in = 1'b0;
    bus.vc_empty  = 5'b11111;
    @(negedge clk);
    checks++; if (bus.credits_avail !== 3'd3) begin fails++; $display("FAIL bnd_sim_unchanged: got %0d, expected 3", bus.credits_avail); end
    // Mid-stream reset while the link is busy.
    for (int i = 0; i < 4; i++) data_arr[i] = 32'h9000_0000 + 32'(i);
    set_data();
    step();
    bus.vc_empty = 5'b10000;
    @(negedge clk);
    checks++; if (bus.grant !== 5'b00010) begin fails++; $display("FAIL bnd_stream_grant0: got %b, expected 00010", bus.grant); end
    exp_q.push_back(data_arr[1]);
    step();
    @(negedge clk);
    checks++; if (bus.grant !== 5'b00100) begin fails++; $display("FAIL bnd_stream_grant1: got %b, expected 00100", bus.grant); end
    exp_q.push_back(data_arr[2]);
    step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bnd_rst_valid: got %b, expected 0", bus.out_valid); end
    checks++; if (bus.out_packet !== 32'h0) begin fails++; $display("FAIL bnd_rst_packet: got %h, expected 0", bus.out_packet); end
    checks++; if (bus.credits_avail !== 3'd4) begin fails++; $display("FAIL bnd_rst_credits: got %0d, expected 4", bus.credits_avail); end
    checks++; if (bus.credit_err !== 1'b0) begin fails++; $display("FAIL bnd_rst_err: got %b, expected 0", bus.credit_err); end
    checks++; if (bus.grant !== 5'b00000) begin fails++; $display("FAIL bnd_rst_grant: got %b, expected 00000", bus.grant); end
    step();
    bus.vc_empty = 5'b11111;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.vc_empty  = 5'b11111;
    bus.vc_data   = '0;
    bus.out_ready = 1'b1;
    bus.credit_in = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_credit_exhaustion();
    test_back_pressure();
    test_boundary();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL final_queue: %0d flits outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/noc_output_scheduler.md
Name: noc_output_scheduler

Overview:
- Scheduler that shares one router output link among five per-input virtual channels (N, S, E, W, Local).
- Selects at most one non-empty VC per cycle and pops it through a one-hot grant.
- Registers the selected flit onto a valid/ready output link.
- Gates every grant on a downstream credit counter, so the adjacent router's input buffer can never overflow.
- Network ports (N, S, E, W) are served round-robin. Local is lower priority but protected by a starvation limit.

Parameters:
- NUM_PORTS, 5, requester count; index 0=N, 1=S, 2=E, 3=W, 4=Local (fixed ordering).
- DATA_WIDTH, 32, flit width.
- CREDITS, 4, downstream buffer depth (initial credit count).
- STARVE_LIMIT, 8, number of consecutive eligible cycles Local may lose before it is force-granted.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- vc_empty  in  NUM_PORTS  per-VC empty flag, one bit per port
- vc_data  in  NUM_PORTS*DATA_WIDTH  VC head flits; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- grant  out  NUM_PORTS  one-hot combinational pop/read-enable to the VCs
- out_packet  out  DATA_WIDTH  registered output flit
- out_valid  out  1  output flit valid
- out_ready  in  1  downstream accepts flit
- credit_in  in  1  single-cycle pulse: downstream freed one buffer slot
- credits_avail  out  clog2(CREDITS+1)  current credit count
- credit_err  out  1  sticky flag: credit overflow seen

Behaviour:
- Reset (async, any time, including mid-transfer) forces:
  - out_valid=0, out_packet=0
  - credits_avail=CREDITS, credit_err=0
  - RR pointer=0, starvation counter=0
  - grant=0 while reset is asserted
- Slot free: slot_free = !out_valid || out_ready (pipelined register; no bubble under back-pressure release).
- Eligible: eligible = slot_free && (credits_avail != 0). When not eligible, grant=0.
- Request vector: req[i] = !vc_empty[i].
- Network arbitration:
  - Rotating priority over req[3:0], starting at the RR pointer.
  - After a grant to port k (k in 0..3): pointer <= (k+1) mod 4.
  - A Local grant does not move the pointer.
- Local arbitration:
  - Local is granted only when eligible and req[3:0]==0, or when the starvation counter == STARVE_LIMIT.
  - A forced Local grant overrides any network request for that cycle.
- Starvation counter:
  - Increments on each eligible cycle where req[4]=1 and Local is not granted.
  - Clears on a Local grant, or when req[4]=0.
  - Saturates at STARVE_LIMIT.
- Grant properties: grant is one-hot or zero, never multi-hot, and is never asserted to an empty VC.
- Output register: on any grant, out_packet <= vc_data slice of the granted port and out_valid <= 1 on the next edge (one-cycle latency). Otherwise:
  - if out_valid && out_ready: out_valid <= 0
  - else hold out_packet and out_valid unchanged.
- Credits: counter is decremented on a grant (slot reserved) and incremented on credit_in.
  - Grant and credit_in in the same cycle: count unchanged.
  - credit_in while count == CREDITS and no grant that cycle: count stays at CREDITS, credit_err <= 1 (sticky until reset).
  - Count never underflows; a count of 0 blocks all grants.
- Output is independent of credit_in timing; out_ready alone completes the link handshake.

Decomposition:
- noc_pkg (shared):
  - port index constants PORT_N, PORT_S, PORT_E, PORT_W, PORT_L
  - NUM_PORTS
  - FLIT_WIDTH=32
  - flit typedef
- One sub-module, rr_priority_picker: combinational 4-input rotating-priority picker; inputs req[3:0] and ptr[1:0]; outputs one-hot gnt[3:0] and any.
- Counters, starvation logic and the output register stay in noc_output_scheduler.

Test Plan:
- Single request: reset, then vc_empty=5'b11110, vc_data N slot=32'hA5A5_0001, out_ready=1 -> grant=00001 in cycle 1; out_packet=A5A5_0001, out_valid=1 in cycle 2; credits_avail 4->3.
- Round-robin: N, S, E, W all non-empty, ample credits, out_ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- Local starvation: N and Local permanently non-empty, STARVE_LIMIT=8, credit_in pulsed each cycle -> Local granted on the 9th eligible cycle; starvation counter returns to 0 afterwards.
- Credit exhaustion: 4 grants with no credit_in -> credits_avail=0 and grant stays 0; one credit_in pulse -> exactly one further grant, with credits_avail returning to 0.
- Back-pressure: out_ready=0 with out_valid=1 -> grant=0 and out_packet held stable for 5 cycles; out_ready=1 -> next flit loads in the same cycle, no bubble.
- Boundary/reset:
  - credit_in at credits_avail=4 with no grant -> credit_err=1 and count stays 4.
  - Simultaneous grant and credit_in -> count unchanged.
  - rst_n low mid-stream -> out_valid=0, credits_avail=4 immediately.
